// File: rtl/noc_flit_packetizer_if.sv
`default_nettype none
// ============================================================================
// noc_flit_packetizer_if : descriptor, body-word, flit and credit bundle
// Revision 1.0
// ============================================================================
interface noc_flit_packetizer_if #(
   parameter int MESH_X    = 6,
   parameter int MESH_Y    = 6,
   parameter int PAYLOAD_W = 16,
   parameter int VC_NUM    = 4,
   parameter int MAX_LEN   = 8
);
   localparam int XW     = $clog2(MESH_X);
   localparam int YW     = $clog2(MESH_Y);
   localparam int FLIT_W = XW + YW + PAYLOAD_W;
   localparam int VCW    = $clog2(VC_NUM);
   localparam int LENW   = $clog2(MAX_LEN + 1);

   logic                    pkt_valid_i;
   logic                    pkt_ready_o;
   logic [XW-1:0]           pkt_x_dest_i;
   logic [YW-1:0]           pkt_y_dest_i;
   logic [LENW-1:0]         pkt_len_i;
   logic [PAYLOAD_W-1:0]    pkt_payload_i;
   logic                    body_valid_i;
   logic                    body_ready_o;
   logic [FLIT_W-1:0]       body_data_i;
   logic                    flit_valid_o;
   logic [2+VCW+FLIT_W-1:0] flit_o;
   logic [VC_NUM-1:0]       credit_i;
   logic                    busy_o;
   logic                    err_o;

   modport slave (
      input  pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i, pkt_payload_i,
      input  body_valid_i, body_data_i, credit_i,
      output pkt_ready_o, body_ready_o, flit_valid_o, flit_o, busy_o, err_o
   );

   modport master (
      output pkt_valid_i, pkt_x_dest_i, pkt_y_dest_i, pkt_len_i, pkt_payload_i,
      output body_valid_i, body_data_i, credit_i,
      input  pkt_ready_o, body_ready_o, flit_valid_o, flit_o, busy_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/noc_flit_packetizer.sv
`default_nettype none
// ============================================================================
// noc_flit_packetizer : descriptor + body words -> typed flits with per-VC credits
// Revision 1.0
// ============================================================================
module noc_flit_packetizer #(
   parameter int MESH_X    = 6,
   parameter int MESH_Y    = 6,
   parameter int PAYLOAD_W = 16,
   parameter int VC_NUM    = 4,
   parameter int BUF_DEPTH = 4,
   parameter int MAX_LEN   = 8
) (
   input wire clk,
   input wire rst,
   noc_flit_packetizer_if.slave bus
);
   localparam int XW     = $clog2(MESH_X);
   localparam int YW     = $clog2(MESH_Y);
   localparam int FLIT_W = XW + YW + PAYLOAD_W;
   localparam int VCW    = $clog2(VC_NUM);
   localparam int LENW   = $clog2(MAX_LEN + 1);
   localparam int CW     = $clog2(BUF_DEPTH + 1);
   localparam int OUT_W  = 2 + VCW + FLIT_W;

   localparam logic [1:0]      LBL_HEAD     = 2'd0;
   localparam logic [1:0]      LBL_BODY     = 2'd1;
   localparam logic [1:0]      LBL_TAIL     = 2'd2;
   localparam logic [1:0]      LBL_HEADTAIL = 2'd3;
   localparam logic [LENW-1:0] LEN_ONE      = LENW'(1);
   localparam logic [LENW-1:0] LEN_MAX      = LENW'(MAX_LEN);
   localparam logic [CW-1:0]   CRED_FULL    = CW'(BUF_DEPTH);
   localparam logic [CW-1:0]   CRED_ONE     = CW'(1);
   localparam logic [VCW-1:0]  VC_LAST      = VCW'(VC_NUM - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_BODY  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [XW-1:0]          x_q, x_d;
   logic [YW-1:0]          y_q, y_d;
   logic [PAYLOAD_W-1:0]   payload_q, payload_d;
   logic [LENW-1:0]        len_q, len_d;
   logic [LENW-1:0]        rem_q, rem_d;
   logic [VCW-1:0]         vc_q, vc_d;
   logic [VCW-1:0]         rr_q, rr_d;
   logic [CW-1:0]          credit_q [VC_NUM];
   logic [CW-1:0]          credit_d [VC_NUM];
   logic                   flit_valid_q, flit_valid_d;
   logic [OUT_W-1:0]       flit_q, flit_d;
   logic                   err_q, err_d;

   logic                   pkt_ready;
   logic                   body_ready;
   logic                   issue;
   logic [VCW-1:0]         issue_vc;
   logic [1:0]             label;
   logic                   pick_found;
   logic [VCW-1:0]         pick_vc;
   logic [VCW-1:0]         cand;

   // Scan offsets high-to-low so the lowest offset from rr_q is the last writer.
   always_comb begin
      pick_found = 1'b0;
      pick_vc    = rr_q;
      cand       = '0;
      for (int i = VC_NUM - 1; i >= 0; i--) begin
         cand = VCW'((int'(rr_q) + i) % VC_NUM);
         if (credit_q[cand] != '0) begin
            pick_found = 1'b1;
            pick_vc    = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      payload_d    = payload_q;
      len_d        = len_q;
      rem_d        = rem_q;
      vc_d         = vc_q;
      rr_d         = rr_q;
      err_d        = err_q;
      flit_valid_d = 1'b0;
      flit_d       = flit_q;
      pkt_ready    = 1'b0;
      body_ready   = 1'b0;
      issue        = 1'b0;
      issue_vc     = vc_q;
      label        = LBL_HEAD;

      case (state_q)
         ST_IDLE: begin
            pkt_ready = 1'b1;
            if (bus.pkt_valid_i) begin
               x_d       = bus.pkt_x_dest_i;
               y_d       = bus.pkt_y_dest_i;
               payload_d = bus.pkt_payload_i;
               if (bus.pkt_len_i == '0) begin
                  len_d = LEN_ONE;
               end else if (bus.pkt_len_i > LEN_MAX) begin
                  len_d = LEN_MAX;
                  err_d = 1'b1;
               end else begin
                  len_d = bus.pkt_len_i;
               end
               state_d = ST_ALLOC;
            end
         end
         ST_ALLOC: begin
            if (pick_found) begin
               issue        = 1'b1;
               issue_vc     = pick_vc;
               vc_d         = pick_vc;
               rr_d         = (pick_vc == VC_LAST) ? '0 : pick_vc + VCW'(1);
               rem_d        = len_q - LEN_ONE;
               label        = (len_q == LEN_ONE) ? LBL_HEADTAIL : LBL_HEAD;
               flit_valid_d = 1'b1;
               flit_d       = {label, pick_vc, x_q, y_q, payload_q};
               state_d      = (len_q == LEN_ONE) ? ST_IDLE : ST_BODY;
            end
         end
         ST_BODY: begin
            body_ready = (credit_q[vc_q] != '0);
            if (bus.body_valid_i && body_ready) begin
               issue        = 1'b1;
               label        = (rem_q == LEN_ONE) ? LBL_TAIL : LBL_BODY;
               flit_valid_d = 1'b1;
               flit_d       = {label, vc_q, bus.body_data_i};
               rem_d        = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A return and an issue on the same VC cancel out; a return to a full counter is an error.
      for (int v = 0; v < VC_NUM; v++) begin
         credit_d[v] = credit_q[v];
         if (bus.credit_i[v] && !(issue && issue_vc == VCW'(v))) begin
            if (credit_q[v] == CRED_FULL) begin
               err_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + CRED_ONE;
            end
         end else if (!bus.credit_i[v] && issue && issue_vc == VCW'(v)) begin
            credit_d[v] = credit_q[v] - CRED_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         x_q          <= '0;
         y_q          <= '0;
         payload_q    <= '0;
         len_q        <= '0;
         rem_q        <= '0;
         vc_q         <= '0;
         rr_q         <= '0;
         err_q        <= 1'b0;
         flit_valid_q <= 1'b0;
         flit_q       <= '0;
         for (int v = 0; v < VC_NUM; v++) begin
            credit_q[v] <= CRED_FULL;
         end
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         payload_q    <= payload_d;
         len_q        <= len_d;
         rem_q        <= rem_d;
         vc_q         <= vc_d;
         rr_q         <= rr_d;
         err_q        <= err_d;
         flit_valid_q <= flit_valid_d;
         flit_q       <= flit_d;
         for (int v = 0; v < VC_NUM; v++) begin
            credit_q[v] <= credit_d[v];
         end
      end
   end

   assign bus.pkt_ready_o  = pkt_ready;
   assign bus.body_ready_o = body_ready;
   assign bus.flit_valid_o = flit_valid_q;
   assign bus.flit_o       = flit_q;
   assign bus.busy_o       = (state_q != ST_IDLE);
   assign bus.err_o        = err_q;
endmodule
`default_nettype wire
